// File: rtl/data_decrypt_framer_pkg.sv
// Shared definitions for the receive-side decrypt framer: FSM states, scrambler taps
// and the default frame alignment byte.
package data_decrypt_framer_pkg;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_CHECK = 2'd1,
    ST_LOCK  = 2'd2
  } frm_state_e;

  // Polynomial 1 + x^4 + x^7
  localparam int SCR_TAP_A = 4;
  localparam int SCR_TAP_B = 7;

  localparam logic [7:0] DEF_SYNC_WORD = 8'hA5;

endpackage

// File: rtl/data_descrambler.sv
// Self-synchronising descrambler for 1 + x^4 + x^7; o_bit is the combinational
// descrambled version of the code bit presented this cycle.
module data_descrambler
  import data_decrypt_framer_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_code,
  output logic o_bit
);

  logic [SCR_TAP_B-1:0] sr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sr <= '0;
    else          sr <= {sr[SCR_TAP_B-2:0], i_code};
  end

  assign o_bit = i_code ^ sr[SCR_TAP_A-1] ^ sr[SCR_TAP_B-1];

endmodule

// File: rtl/data_decrypt_framer.sv
// Receive framer: descrambles the serial code stream, hunts for SYNC_WORD, locks with
// hysteresis and emits payload bytes while locked.
module data_decrypt_framer
  import data_decrypt_framer_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD     = DEF_SYNC_WORD,
  parameter int         PAYLOAD_BYTES = 4,
  parameter int         LOCK_CNT      = 2,
  parameter int         MISS_CNT      = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_code,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_locked,
  output logic       o_sync_err
);

  localparam int FRAME = 8 * (PAYLOAD_BYTES + 1);
  localparam int BW    = $clog2(FRAME);
  localparam int CMAX  = (LOCK_CNT > MISS_CNT) ? LOCK_CNT : MISS_CNT;
  localparam int CW    = $clog2(CMAX + 1);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic [CW-1:0] lim);
    return (v >= lim) ? v : v + 1'b1;
  endfunction

  frm_state_e    state, state_n;
  logic [BW-1:0] bit_cnt, bit_cnt_n;
  logic [CW-1:0] good_cnt, good_n;
  logic [CW-1:0] miss_cnt, miss_n;
  logic [6:0]    win;
  logic          d;
  logic [7:0]    cand;
  logic          hit, at_sync, at_byte;
  logic          valid_n, err_n;

  data_descrambler u_descr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_code  (i_code),
    .o_bit   (d)
  );

  // The byte completing on this edge includes the bit being sampled now
  assign cand    = {win, d};
  assign hit     = (cand == SYNC_WORD);
  assign at_sync = (bit_cnt == '0);
  assign at_byte = (bit_cnt[2:0] == 3'd0) && !at_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_HUNT;
    else          state <= state_n;
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = (bit_cnt == BW'(FRAME - 1)) ? '0 : bit_cnt + 1'b1;
    good_n    = good_cnt;
    miss_n    = miss_cnt;
    valid_n   = 1'b0;
    err_n     = 1'b0;
    case (state)
      ST_HUNT: begin
        bit_cnt_n = '0;
        if (hit) begin
          bit_cnt_n = BW'(1);
          good_n    = CW'(1);
          miss_n    = '0;
          state_n   = (LOCK_CNT == 1) ? ST_LOCK : ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (at_sync) begin
          if (hit) begin
            good_n = sat_inc(good_cnt, CW'(LOCK_CNT));
            if (good_n >= CW'(LOCK_CNT)) begin
              state_n = ST_LOCK;
              miss_n  = '0;
            end
          end else begin
            state_n = ST_HUNT;
          end
        end
      end
      ST_LOCK: begin
        if (at_sync) begin
          if (hit) begin
            miss_n = '0;
          end else begin
            err_n  = 1'b1;
            miss_n = sat_inc(miss_cnt, CW'(MISS_CNT));
            if (miss_n >= CW'(MISS_CNT)) state_n = ST_HUNT;
          end
        end else if (at_byte) begin
          valid_n = 1'b1;
        end
      end
      default: state_n = ST_HUNT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bit_cnt    <= '0;
      good_cnt   <= '0;
      miss_cnt   <= '0;
      win        <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_locked   <= 1'b0;
      o_sync_err <= 1'b0;
    end else begin
      bit_cnt    <= bit_cnt_n;
      good_cnt   <= good_n;
      miss_cnt   <= miss_n;
      win        <= cand[6:0];
      o_valid    <= valid_n;
      o_sync_err <= err_n;
      o_locked   <= (state_n == ST_LOCK);
      if (valid_n) o_data <= cand;
    end
  end

endmodule

// File: tb/tb_data_decrypt_framer.sv
// Bench for data_decrypt_framer: scrambled frames in, outputs compared every cycle
// against a bit-history reference model plus directed scenario expectations.
module tb_data_decrypt_framer;

  localparam int FRAME    = 40;
  localparam int LOCK_CNT = 2;
  localparam int MISS_CNT = 3;
  localparam int M_SEARCH  = 0;
  localparam int M_CONFIRM = 1;
  localparam int M_LOCKED  = 2;
  localparam logic [31:0] PL = 32'h01020304;

  logic       clk;
  logic       i_rst_n;
  logic       i_code;
  logic [7:0] o_data;
  logic       o_valid, o_locked, o_sync_err;

  data_decrypt_framer dut (
    .i_clk      (clk),
    .i_rst_n    (i_rst_n),
    .i_code     (i_code),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_locked   (o_locked),
    .o_sync_err (o_sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // link-side scrambler history and receive-side code/plain history since reset
  logic tx_hist[$];
  logic rx_code[$];
  logic rx_d[$];

  int         m_mode, anchor, good, misses;
  logic       e_valid, e_err;
  logic [7:0] e_data;

  logic [7:0] rxq[$];
  int         err_seen, lock_edge, prelock;
  logic       prev_locked;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic tx_bit(input int k);
    if (tx_hist.size() < k) return 1'b0;
    return tx_hist[tx_hist.size() - k];
  endfunction

  function automatic logic code_at(input int i);
    if (i < 0) return 1'b0;
    return rx_code[i];
  endfunction

  function automatic logic [7:0] word_at(input int n);
    logic [7:0] w = '0;
    for (int i = n - 7; i <= n; i++) w = {w[6:0], (i < 0) ? 1'b0 : rx_d[i]};
    return w;
  endfunction

  task automatic model_reset();
    rx_code.delete();
    rx_d.delete();
    m_mode  = M_SEARCH;
    anchor  = 0;
    good    = 0;
    misses  = 0;
    e_valid = 1'b0;
    e_err   = 1'b0;
    e_data  = 8'h00;
  endtask

  task automatic model_step(input logic c);
    int n, off;
    logic [7:0] w;
    logic hit;
    rx_code.push_back(c);
    n = rx_code.size() - 1;
    rx_d.push_back(c ^ code_at(n - 4) ^ code_at(n - 7));
    w   = word_at(n);
    hit = (w == 8'hA5);
    e_valid = 1'b0;
    e_err   = 1'b0;
    off = (n - anchor) % FRAME;
    case (m_mode)
      M_SEARCH: if (hit) begin
        anchor = n;
        good   = 1;
        m_mode = (LOCK_CNT == 1) ? M_LOCKED : M_CONFIRM;
      end
      M_CONFIRM: if (off == 0) begin
        if (hit) begin
          good++;
          if (good >= LOCK_CNT) begin m_mode = M_LOCKED; misses = 0; end
        end else m_mode = M_SEARCH;
      end
      default: begin
        if (off == 0) begin
          if (hit) misses = 0;
          else begin
            e_err = 1'b1;
            misses++;
            if (misses >= MISS_CNT) m_mode = M_SEARCH;
          end
        end else if (off % 8 == 0) begin
          e_valid = 1'b1;
          e_data  = w;
        end
      end
    endcase
  endtask

  task automatic clear_obs();
    rxq.delete();
    err_seen = 0;
    prelock  = 0;
  endtask

  task automatic tick(input logic p, input logic cf);
    logic c;
    c = p ^ tx_bit(4) ^ tx_bit(7);
    tx_hist.push_back(c);
    if (tx_hist.size() > 8) void'(tx_hist.pop_front());
    i_code = c ^ cf;
    @(posedge clk);
    #1;
    model_step(c ^ cf);
    check_val("valid", o_valid, e_valid);
    check_val("sync_err", o_sync_err, e_err);
    check_val("locked", o_locked, m_mode == M_LOCKED);
    check_val("data", o_data, e_data);
    if (o_valid) rxq.push_back(o_data);
    if (o_sync_err) err_seen++;
    if ((!o_locked && o_valid) || (!o_locked && !prev_locked && o_sync_err)) prelock++;
    if (o_locked && !prev_locked && lock_edge < 0) lock_edge = rx_code.size() - 1;
    prev_locked = o_locked;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [7:0] pf, input logic [7:0] cf);
    for (int i = 7; i >= 0; i--) tick(b[i] ^ pf[i], cf[i]);
  endtask

  task automatic send_frame(input logic [31:0] pl, input logic [7:0] sync_pf,
                            input int cf_idx, input logic [7:0] cf_mask);
    send_byte(8'hA5, sync_pf, (cf_idx == 0) ? cf_mask : 8'h00);
    for (int k = 0; k < 4; k++)
      send_byte(pl[31 - 8*k -: 8], 8'h00, (cf_idx == k + 1) ? cf_mask : 8'h00);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    model_reset();
    #1;
    check_val("rst_data", o_data, 8'h00);
    check_val("rst_valid", o_valid, 1'b0);
    check_val("rst_locked", o_locked, 1'b0);
    check_val("rst_err", o_sync_err, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    i_rst_n     = 1'b1;
    lock_edge   = -1;
    prev_locked = 1'b0;
    clear_obs();
  endtask

  task automatic run_clean_lock();
    do_reset();
    send_byte(8'h00, 8'h00, 8'h00);
    send_byte(8'h00, 8'h00, 8'h00);
    repeat (6) send_frame(PL, 8'h00, -1, 8'h00);
    check_val("lock_edge", lock_edge, 63);
    check_val("byte_count", rxq.size(), 20);
    for (int i = 0; i < rxq.size(); i++) check_val("payload", rxq[i], (i % 4) + 1);
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_code  = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // clean lock and payload cadence
    run_clean_lock();

    // single bad SYNC while locked
    clear_obs();
    send_frame(PL, 8'h10, -1, 8'h00);
    repeat (2) send_frame(PL, 8'h00, -1, 8'h00);
    check_val("single_err", err_seen, 1);
    check_val("still_locked", o_locked, 1'b1);
    check_val("bytes_after_err", rxq.size(), 12);
    for (int i = 0; i < rxq.size(); i++) check_val("payload_after_err", rxq[i], (i % 4) + 1);

    // three bad SYNCs drop lock, then relock
    clear_obs();
    repeat (3) send_frame(PL, 8'h01, -1, 8'h00);
    check_val("drop_errs", err_seen, 3);
    check_val("dropped", o_locked, 1'b0);
    check_val("bytes_before_drop", rxq.size(), 8);
    send_frame(PL, 8'h00, -1, 8'h00);
    check_val("relock_pending", o_locked, 1'b0);
    send_frame(PL, 8'h00, -1, 8'h00);
    check_val("relocked", o_locked, 1'b1);

    // false SYNC inside payload before first lock
    do_reset();
    send_byte(8'h00, 8'h00, 8'h00);
    send_byte(8'h00, 8'h00, 8'h00);
    send_byte(8'h00, 8'h00, 8'h00);
    send_byte(8'hA5, 8'h00, 8'h00);
    send_byte(8'h00, 8'h00, 8'h00);
    send_byte(8'h00, 8'h00, 8'h00);
    repeat (4) send_frame(PL, 8'h00, -1, 8'h00);
    check_val("true_lock_edge", lock_edge, 135);
    check_val("prelock_events", prelock, 0);
    check_val("false_sync_bytes", rxq.size(), 8);

    // one code-bit error in payload byte 2 -> three plain errors inside that byte
    clear_obs();
    send_frame(PL, 8'h00, 2, 8'h80);
    send_frame(PL, 8'h00, -1, 8'h00);
    check_val("code_err_count", rxq.size(), 8);
    if (rxq.size() == 8) begin
      check_val("code_err_b0", rxq[0], 8'h01);
      check_val("code_err_b1", rxq[1], 8'h8B);
      check_val("code_err_b2", rxq[2], 8'h03);
      check_val("code_err_b3", rxq[3], 8'h04);
    end
    check_val("code_err_locked", o_locked, 1'b1);
    check_val("code_err_no_sync_err", err_seen, 0);

    // asynchronous reset mid-byte while locked
    send_byte(8'hA5, 8'h00, 8'h00);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    #3;
    i_rst_n = 1'b0;
    #1;
    check_val("async_data", o_data, 8'h00);
    check_val("async_valid", o_valid, 1'b0);
    check_val("async_locked", o_locked, 1'b0);
    check_val("async_err", o_sync_err, 1'b0);
    @(posedge clk);
    #1;
    run_clean_lock();

    // randomized frames with sporadic SYNC and line errors
    do_reset();
    send_byte(8'h00, 8'h00, 8'h00);
    send_byte(8'h00, 8'h00, 8'h00);
    for (int f = 0; f < 40; f++) begin
      logic [31:0] pl;
      logic [7:0]  spf, cm;
      int          ci;
      pl  = $urandom;
      spf = ($urandom_range(0, 7) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      ci  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
      cm  = 8'h01 << $urandom_range(0, 7);
      send_frame(pl, spf, ci, cm);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
